// File: rtl/seq_mult_shift_add.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Unsigned or two's-complement operands, START/READY/BUSY/DONE handshake.
module seq_mult_shift_add #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               START,
  input  logic               SIGNED_MODE,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               READY,
  output logic               BUSY,
  output logic               DONE
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t nstate;

  logic accept;
  logic last;

  logic [CW-1:0]    cnt;
  logic             smode;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   acc;

  logic [WIDTH:0]   mext;
  logic [WIDTH+1:0] ax;
  logic [WIDTH+1:0] mx;
  logic [WIDTH+1:0] sum;
  logic             do_sub;
  logic             shin;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] mpl_nx;

  assign last = (cnt == CW'(WIDTH - 1));

  // State register; reset aborts any operation in flight
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next-state and handshake outputs decoded from the current state
  always_comb begin
    nstate = state;
    READY  = 1'b0;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    accept = 1'b0;
    unique case (state)
      S_IDLE: begin
        READY = 1'b1;
        if (START) begin
          accept = 1'b1;
          nstate = S_RUN;
        end
      end
      S_RUN: begin
        BUSY = 1'b1;
        if (last) begin
          nstate = S_DONE;
        end
      end
      S_DONE: begin
        READY = 1'b1;
        DONE  = 1'b1;
        if (START) begin
          accept = 1'b1;
          nstate = S_RUN;
        end else begin
          nstate = S_IDLE;
        end
      end
      default: begin
        nstate = S_IDLE;
      end
    endcase
  end

  // One add/subtract-and-shift step of the partial product
  always_comb begin
    mext   = smode ? {mcand[WIDTH-1], mcand}
                   : {1'b0, mcand};
    ax     = smode ? {acc[WIDTH], acc}
                   : {1'b0, acc};
    mx     = {smode & mext[WIDTH], mext};
    do_sub = smode & last;
    sum    = ax;
    if (mplier[0]) begin
      sum = do_sub ? (ax - mx) : (ax + mx);
    end
    shin   = smode ? sum[WIDTH] : sum[WIDTH+1];
    acc_nx = {shin, sum[WIDTH:1]};
    mpl_nx = {sum[0], mplier[WIDTH-1:1]};
  end

  // Operand capture, iteration and result load
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      cnt    <= '0;
      smode  <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      P      <= '0;
    end else if (accept) begin
      cnt    <= '0;
      smode  <= SIGNED_MODE & SIGNED_EN;
      mcand  <= A;
      mplier <= B;
      acc    <= '0;
    end else if (BUSY) begin
      cnt    <= cnt + CW'(1);
      acc    <= acc_nx;
      mplier <= mpl_nx;
      if (last) begin
        P <= {acc_nx[WIDTH-1:0], mpl_nx};
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Self-checking bench for seq_mult_shift_add.
// Random and directed ops against an arithmetic reference model.
module tb_seq_mult_shift_add;

  logic CK = 1'b0;
  logic RST = 1'b1;

  logic        s8_start = 1'b0;
  logic        s8_mode = 1'b0;
  logic [7:0]  s8_a = '0;
  logic [7:0]  s8_b = '0;
  logic [15:0] s8_p;
  logic        s8_ready, s8_busy, s8_done;

  logic        q_start = 1'b0;
  logic        s4_mode = 1'b0;
  logic        u4_mode = 1'b1;
  logic [3:0]  q_a = '0;
  logic [3:0]  q_b = '0;
  logic [7:0]  s4_p, u4_p;
  logic        s4_ready, s4_busy, s4_done;
  logic        u4_ready, u4_busy, u4_done;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CK = ~CK;

  seq_mult_shift_add #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .CK(CK), .RST(RST), .START(s8_start),
    .SIGNED_MODE(s8_mode), .A(s8_a), .B(s8_b),
    .P(s8_p), .READY(s8_ready), .BUSY(s8_busy),
    .DONE(s8_done)
  );

  seq_mult_shift_add #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4s (
    .CK(CK), .RST(RST), .START(q_start),
    .SIGNED_MODE(s4_mode), .A(q_a), .B(q_b),
    .P(s4_p), .READY(s4_ready), .BUSY(s4_busy),
    .DONE(s4_done)
  );

  seq_mult_shift_add #(.WIDTH(4), .SIGNED_EN(1'b0)) dut4u (
    .CK(CK), .RST(RST), .START(q_start),
    .SIGNED_MODE(u4_mode), .A(q_a), .B(q_b),
    .P(u4_p), .READY(u4_ready), .BUSY(u4_busy),
    .DONE(u4_done)
  );

  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint ref_mul(longint a, longint b,
                                     bit m, int w);
    longint x, y, lim;
    x = a;
    y = b;
    lim = longint'(1) <<< (w - 1);
    if (m) begin
      if (x >= lim) x = x - (lim * 2);
      if (y >= lim) y = y - (lim * 2);
    end
    return (x * y) & ((longint'(1) <<< (2 * w)) - 1);
  endfunction

  logic        prev_done = 1'b0;
  logic [15:0] prev_p = '0;

  always @(negedge CK) begin
    if (!RST) begin
      chk("rdy_nbusy", s8_ready, !s8_busy);
      chk("done_pulse", prev_done && s8_done, 0);
      if (!s8_done) chk("p_hold", s8_p, prev_p);
    end
    prev_done <= s8_done;
    prev_p    <= s8_p;
  end

  task automatic do8(input logic [7:0] a, input logic [7:0] b,
                     input bit m, input int poke);
    int cyc;
    s8_a = a;
    s8_b = b;
    s8_mode = m;
    s8_start = 1'b1;
    @(posedge CK);
    #1;
    s8_start = 1'b0;
    s8_a = 8'($urandom);
    s8_b = 8'($urandom);
    s8_mode = 1'($urandom);
    cyc = 0;
    while (!s8_done && cyc < 40) begin
      @(posedge CK);
      #1;
      cyc++;
      s8_start = (cyc == poke) && !s8_done;
      if (!s8_done) begin
        s8_a = 8'($urandom);
        s8_b = 8'($urandom);
        s8_mode = 1'($urandom);
      end
    end
    s8_start = 1'b0;
    chk("lat8", cyc, 8);
    chk("p8", s8_p, ref_mul(a, b, m, 8));
  endtask

  task automatic do4(input logic [3:0] a, input logic [3:0] b,
                     input bit m, input longint es,
                     input longint eu);
    int cyc;
    q_a = a;
    q_b = b;
    s4_mode = m;
    q_start = 1'b1;
    @(posedge CK);
    #1;
    q_start = 1'b0;
    cyc = 0;
    while (!s4_done && cyc < 20) begin
      @(posedge CK);
      #1;
      cyc++;
    end
    chk("lat4", cyc, 4);
    chk("p4s", s4_p, es);
    chk("p4u", u4_p, eu);
    chk("done4u", u4_done, 1);
  endtask

  function automatic logic [7:0] pick8();
    logic [7:0] c [4];
    c[0] = 8'h00;
    c[1] = 8'hFF;
    c[2] = 8'h80;
    c[3] = 8'h7F;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    time t1, t2;
    logic [3:0] ra, rb;
    bit rm;
    repeat (2) @(posedge CK);
    #1;
    chk("rst_p", s8_p, 0);
    chk("rst_ready", s8_ready, 1);
    chk("rst_busy", s8_busy, 0);
    chk("rst_done", s8_done, 0);
    chk("rst_p4", s4_p, 0);
    RST = 1'b0;
    @(posedge CK);
    #1;

    do8(8'hFF, 8'hFF, 1'b0, 0);
    chk("umax", s8_p, 16'hFE01);
    @(posedge CK);
    #1;

    s8_a = 8'h37;
    s8_b = 8'h5B;
    s8_mode = 1'b0;
    s8_start = 1'b1;
    @(posedge CK);
    #1;
    s8_start = 1'b0;
    repeat (3) @(posedge CK);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_p", s8_p, 0);
    chk("abort_ready", s8_ready, 1);
    chk("abort_busy", s8_busy, 0);
    chk("abort_done", s8_done, 0);
    @(posedge CK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CK);
      #1;
      chk("abort_nodone", s8_done, 0);
    end

    do8(8'h0C, 8'h0B, 1'b0, 3);
    chk("poke_p", s8_p, 16'd132);
    @(posedge CK);
    #1;

    do8(8'hF3, 8'h21, 1'b1, 0);
    t1 = $time;
    do8(8'h80, 8'h80, 1'b1, 0);
    t2 = $time;
    chk("b2b_gap", longint'((t2 - t1) / 10), 9);
    chk("s8_corner", s8_p, 16'h4000);
    @(posedge CK);
    #1;

    do4(4'hD, 4'h5, 1'b1, 8'hF1, 8'h41);
    @(posedge CK);
    #1;
    do4(4'h8, 4'h8, 1'b1, 8'h40, 8'h40);
    @(posedge CK);
    #1;
    do4(4'hD, 4'h5, 1'b0, 8'h41, 8'h41);
    for (int i = 0; i < 20; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rm = 1'($urandom);
      do4(ra, rb, rm, ref_mul(ra, rb, rm, 4),
          ref_mul(ra, rb, 1'b0, 4));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge CK);
        #1;
      end
    end

    for (int i = 0; i < 1000; i++) begin
      do8(pick8(), pick8(), 1'($urandom),
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge CK);
        #1;
      end
    end

    repeat (3) @(posedge CK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_shift_add.md
Name: seq_mult_shift_add

Overview:
- Parametrised sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Next-generation arithmetic datapath block for the benchmark-circuit library. Adds configurable width, a signed (two's-complement) mode, an explicit busy/done handshake and asynchronous reset, which the earlier fixed 4-bit unsigned multiplier lacks.
- Sits between an operand source issuing START and a consumer sampling P on DONE.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- SIGNED_EN, 1, 1 = SIGNED_MODE input honoured; 0 = SIGNED_MODE ignored, always unsigned.

Ports:
- CK  input  1  clock, rising-edge.
- RST  input  1  asynchronous active-high reset.
- START  input  1  request; accepted only when READY=1.
- SIGNED_MODE  input  1  sampled with START; 1 = two's-complement operands.
- A  input  WIDTH  multiplicand; sampled with START.
- B  input  WIDTH  multiplier; sampled with START.
- P  output  2*WIDTH  product; registered, held until the next completion.
- READY  output  1  high when a new START will be accepted.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse, high in the cycle P first shows a new result.

Behaviour:
- Interface: one clock (CK); reset RST is asynchronous and active-high.
- Reset values (asserted asynchronously, released synchronously to CK):
  - P=0, READY=1, BUSY=0, DONE=0.
  - State IDLE, iteration counter 0, internal accumulator/operand registers 0.
- State IDLE (READY=1, BUSY=0):
  - START=1 at a rising edge: capture A, B and mode (SIGNED_MODE AND SIGNED_EN); clear accumulator; counter=0; go to RUN.
  - START=0: stay in IDLE.
- State RUN (READY=0, BUSY=1): one iteration per edge, WIDTH iterations, counter 0..WIDTH-1.
  - The accumulator is WIDTH+1 bits wide; it holds the high half of the partial product. The low half shifts into the multiplier register.
  - Multiplier LSB=1 and not the last iteration: accumulator += multiplicand. Multiplicand is sign-extended in signed mode, zero-extended in unsigned mode.
  - Last iteration (counter=WIDTH-1) in signed mode with multiplier LSB (the original B MSB) =1: accumulator -= multiplicand.
  - Last iteration in unsigned mode: normal add.
  - After add/subtract, shift the combined {accumulator, multiplier} right by 1. Shift-in bit = accumulator MSB (arithmetic) in signed mode, carry-out in unsigned mode.
  - At counter=WIDTH-1: load the 2*WIDTH result into P and go to DONE.
- State DONE (exactly one cycle): DONE=1, BUSY=0, READY=1, P valid.
  - START=1 in this cycle is accepted (back-to-back): captures new operands and goes to RUN.
  - Otherwise go to IDLE.
- Latency: START accepted at edge k -> P updated at edge k+WIDTH, DONE high for the cycle after edge k+WIDTH.
  - Throughput: one result per WIDTH+1 cycles in back-to-back operation.
- START while BUSY=1: ignored. No effect on the running operation and not queued.
- A, B and SIGNED_MODE changing during RUN: no effect.
- Arithmetic: the result is exact modulo 2^(2*WIDTH); no overflow is possible.
  - Signed -2^(W-1) * -2^(W-1) = +2^(2W-2), correct.
- RST during RUN or DONE: the operation is aborted immediately; P returns to 0; no DONE pulse.
- P changes only at the completion edge or on reset.

Test Plan:
- Reset: assert RST mid-RUN (WIDTH=8, after 3 iterations) -> P=16'h0000, READY=1, BUSY=0, DONE=0 within the same cycle; no DONE ever appears for the aborted op.
- Unsigned max, WIDTH=8: A=8'hFF, B=8'hFF, SIGNED_MODE=0 -> DONE exactly 8 cycles after accept edge, P=16'hFE01.
- Signed mixed, WIDTH=4: A=4'hD (-3), B=4'h5, SIGNED_MODE=1 -> P=8'hF1 (-15). Signed corner A=B=4'h8 -> P=8'h40. Same operands unsigned (13*5) -> P=8'h41.
- SIGNED_EN=0, WIDTH=4: A=4'hD, B=4'h5, SIGNED_MODE=1 -> P=8'h41 (mode ignored).
- Handshake, WIDTH=8:
  - Pulse START during BUSY with new operands -> ignored; P equals the first operation's result.
  - START held high in the DONE cycle -> second operation accepted; its DONE arrives 9 cycles after the first.
- Randomised, WIDTH=8 both modes: 1000 ops vs reference model -> exact match; DONE is always a single-cycle pulse; READY=~BUSY always.
